// File: rtl/aes_pkg.sv
// AES-128 shared definitions: FSM encoding, round constants, GF(2^8)
// arithmetic, S-boxes and single-step key schedule helpers.
package aes_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_KEYGEN,
        ST_FIRST,
        ST_MIDDLE,
        ST_FINAL,
        ST_OUT
    } state_e;

    localparam int unsigned ROUND_MAX = 10;
    // Round counter advance per clock, shared by key build and datapath.
    localparam logic [3:0]  KS_STEP   = 4'd1;
    localparam logic [3:0]  LAST_CNT  = 4'(ROUND_MAX - 1);

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254; maps 0 to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = x;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gmul(sq, sq);
            acc = gmul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] y;
        y = gf_inv(x);
        return y ^ {y[6:0], y[7]} ^ {y[5:0], y[7:6]} ^ {y[4:0], y[7:5]}
                 ^ {y[3:0], y[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] y);
        logic [7:0] z;
        z = {y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05;
        return gf_inv(z);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        logic [7:0] r;
        case (idx)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
        return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
    endfunction

    // Round key r -> r+1 (rc is the round constant of round r+1).
    function automatic logic [127:0] key_fwd(input logic [127:0] rk, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3;
        {w0, w1, w2, w3} = rk;
        w0 = w0 ^ sub_rot_word(w3) ^ {rc, 24'h0};
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // Round key r -> r-1 (rc is the round constant of round r).
    function automatic logic [127:0] key_inv(input logic [127:0] rk, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3;
        {w0, w1, w2, w3} = rk;
        w3 = w3 ^ w2;
        w2 = w2 ^ w1;
        w1 = w1 ^ w0;
        w0 = w0 ^ sub_rot_word(w3) ^ {rc, 24'h0};
        return {w0, w1, w2, w3};
    endfunction

endpackage

// File: rtl/aes128_round.sv
// One combinational AES round, forward or inverse, with optional MixColumns
// bypass for the last round. Byte 0 of the state sits in bits [127:120].
module aes128_round
    import aes_pkg::*;
(
    input  logic [127:0] state_i,
    input  logic [127:0] rkey_i,
    input  logic         dec_i,
    input  logic         last_i,
    output logic [127:0] state_o
);

    function automatic logic [127:0] sub_bytes(input logic [127:0] s, input logic inv);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++)
            o[127 - 8*i -: 8] = inv ? inv_sbox(s[127 - 8*i -: 8]) : sbox(s[127 - 8*i -: 8]);
        return o;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
        logic [127:0] o;
        logic [1:0]   sc;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sc = inv ? 2'(c - r) : 2'(c + r);
                o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*int'(sc) + r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [7:0] mc_coef(input logic inv, input logic [1:0] k);
        logic [7:0] m;
        case (k)
            2'd0:    m = inv ? 8'h0e : 8'h02;
            2'd1:    m = inv ? 8'h0b : 8'h03;
            2'd2:    m = inv ? 8'h0d : 8'h01;
            default: m = inv ? 8'h09 : 8'h01;
        endcase
        return m;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s, input logic inv);
        logic [127:0] o;
        logic [7:0]   b;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                b = 8'h00;
                for (int j = 0; j < 4; j++)
                    b = b ^ gmul(mc_coef(inv, 2'(j - r)), s[127 - 32*c - 8*j -: 8]);
                o[127 - 32*c - 8*r -: 8] = b;
            end
        end
        return o;
    endfunction

    logic [127:0] enc_t;
    logic [127:0] dec_t;

    // Encrypt: SB->SR->(MC)->ARK.  Decrypt: ISR->ISB->ARK->(IMC).
    always_comb begin
        enc_t = shift_rows(sub_bytes(state_i, 1'b0), 1'b0);
        dec_t = sub_bytes(shift_rows(state_i, 1'b1), 1'b1) ^ rkey_i;
        if (dec_i)
            state_o = last_i ? dec_t : mix_columns(dec_t, 1'b1);
        else
            state_o = last_i ? (enc_t ^ rkey_i) : (mix_columns(enc_t, 1'b0) ^ rkey_i);
    end

endmodule

// File: rtl/aes128_stream_core.sv
// Iterative AES-128 block engine, one round per clock, ECB/CBC, encrypt and
// decrypt, with the round-10 key cached so decryption starts immediately.
module aes128_stream_core
    import aes_pkg::*;
#(
    parameter bit           CBC_EN = 1'b1,
    parameter logic [127:0] IV_RST = 128'h0
) (
    input  logic         i_Clk,
    input  logic         i_Rst,
    input  logic         i_fKeyLoad,
    input  logic [127:0] i_Key,
    input  logic         i_fIvLoad,
    input  logic [127:0] i_Iv,
    input  logic         i_Valid,
    output logic         o_Ready,
    input  logic         i_fDec,
    input  logic         i_fCbc,
    input  logic [127:0] i_Text,
    output logic         o_Valid,
    input  logic         i_Ready,
    output logic [127:0] o_Data,
    output logic         o_fKeyRdy
);

    state_e       state_q, state_d;
    logic [127:0] key_q, key_d;       // cipher key (round key 0)
    logic [127:0] cache_q, cache_d;   // round key 10
    logic [127:0] rk_q, rk_d;         // round key in use this cycle
    logic [127:0] data_q, data_d;     // cipher state / result
    logic [127:0] ct_q, ct_d;         // ciphertext copy for CBC decrypt
    logic [127:0] iv_q, iv_d;
    logic [3:0]   cnt_q, cnt_d;
    logic         dec_q, dec_d;
    logic         cbc_q, cbc_d;
    logic         keyrdy_q, keyrdy_d;

    logic [127:0] round_s, rk_fwd, rk_step, result;
    logic         last_s, take_key;

    assign last_s  = (state_q == ST_FINAL);
    assign rk_fwd  = key_fwd(rk_q, rcon(cnt_q + KS_STEP));
    assign rk_step = dec_q ? key_inv(rk_q, rcon(4'(ROUND_MAX) - cnt_q)) : rk_fwd;

    aes128_round u_round (
        .state_i (data_q),
        .rkey_i  (rk_q),
        .dec_i   (dec_q),
        .last_i  (last_s),
        .state_o (round_s)
    );

    assign o_Ready   = (state_q == ST_IDLE) && keyrdy_q && !i_fKeyLoad;
    assign o_Valid   = (state_q == ST_OUT);
    assign o_Data    = o_Valid ? data_q : '0;
    assign o_fKeyRdy = keyrdy_q;
    assign take_key  = i_fKeyLoad &&
                       ((state_q == ST_IDLE) || ((state_q == ST_OUT) && i_Ready));

    // Next-state, key schedule, datapath and chaining updates.
    always_comb begin
        state_d  = state_q;
        key_d    = key_q;
        cache_d  = cache_q;
        rk_d     = rk_q;
        data_d   = data_q;
        ct_d     = ct_q;
        iv_d     = iv_q;
        cnt_d    = cnt_q;
        dec_d    = dec_q;
        cbc_d    = cbc_q;
        keyrdy_d = keyrdy_q;
        result   = (cbc_q && dec_q) ? (round_s ^ iv_q) : round_s;

        if (take_key) begin
            key_d    = i_Key;
            rk_d     = i_Key;
            cnt_d    = '0;
            keyrdy_d = 1'b0;
            state_d  = ST_KEYGEN;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_fIvLoad && CBC_EN) iv_d = i_Iv;
                    if (i_Valid && o_Ready) begin
                        dec_d   = i_fDec;
                        cbc_d   = CBC_EN && i_fCbc;
                        data_d  = (CBC_EN && i_fCbc && !i_fDec) ? (i_Text ^ iv_q) : i_Text;
                        ct_d    = i_Text;
                        rk_d    = i_fDec ? cache_q : key_q;
                        cnt_d   = '0;
                        state_d = ST_FIRST;
                    end
                end
                ST_KEYGEN: begin
                    rk_d = rk_fwd;
                    if (cnt_q == LAST_CNT) begin
                        cache_d  = rk_fwd;
                        keyrdy_d = 1'b1;
                        state_d  = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + KS_STEP;
                    end
                end
                ST_FIRST: begin
                    data_d  = data_q ^ rk_q;
                    rk_d    = rk_step;
                    cnt_d   = cnt_q + KS_STEP;
                    state_d = ST_MIDDLE;
                end
                ST_MIDDLE: begin
                    data_d = round_s;
                    rk_d   = rk_step;
                    cnt_d  = cnt_q + KS_STEP;
                    if (cnt_q == LAST_CNT) state_d = ST_FINAL;
                end
                ST_FINAL: begin
                    data_d = result;
                    if (cbc_q) iv_d = dec_q ? ct_q : result;
                    state_d = ST_OUT;
                end
                ST_OUT: begin
                    if (i_Ready) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State and datapath registers; reset aborts any block and drops the key.
    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            state_q  <= ST_IDLE;
            key_q    <= '0;
            cache_q  <= '0;
            rk_q     <= '0;
            data_q   <= '0;
            ct_q     <= '0;
            iv_q     <= IV_RST;
            cnt_q    <= '0;
            dec_q    <= 1'b0;
            cbc_q    <= 1'b0;
            keyrdy_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            key_q    <= key_d;
            cache_q  <= cache_d;
            rk_q     <= rk_d;
            data_q   <= data_d;
            ct_q     <= ct_d;
            iv_q     <= iv_d;
            cnt_q    <= cnt_d;
            dec_q    <= dec_d;
            cbc_q    <= cbc_d;
            keyrdy_q <= keyrdy_d;
        end
    end

endmodule

// File: tb/tb_aes128_stream_core.sv
// Directed bench for aes128_stream_core: FIPS-197 and SP800-38A vectors,
// backpressure, key-load priority and mid-block reset, with a result queue.
`timescale 1ns/1ps
module tb_aes128_stream_core;

    logic         i_Clk      = 1'b0;
    logic         i_Rst      = 1'b0;
    logic         i_fKeyLoad = 1'b0;
    logic [127:0] i_Key      = '0;
    logic         i_fIvLoad  = 1'b0;
    logic [127:0] i_Iv       = '0;
    logic         i_Valid    = 1'b0;
    logic         o_Ready;
    logic         i_fDec     = 1'b0;
    logic         i_fCbc     = 1'b0;
    logic [127:0] i_Text     = '0;
    logic         o_Valid;
    logic         i_Ready    = 1'b0;
    logic [127:0] o_Data;
    logic         o_fKeyRdy;

    localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] IV2 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PA  = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] PB  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam logic [127:0] CA  = 128'h7649abac8119b246cee98e9b12e9197d;
    localparam logic [127:0] CB  = 128'h5086cb9b507219ee95db113a917678b2;
    localparam logic [127:0] EA  = 128'h3ad77bb40d7a3660a89ecaf32466ef97; // ECB(K2, PA)

    // Edges from the accept edge until o_Valid is first seen (12th cycle).
    localparam int BLK_LAT = 11;
    // Edges from the key-load edge until o_fKeyRdy is first seen (11th cycle).
    localparam int KEY_LAT = 10;

    int           n_checks = 0;
    int           n_errors = 0;
    int           cyc      = 0;
    int           acc_cyc  = 0;
    logic [127:0] exp_q[$];

    aes128_stream_core dut (
        .i_Clk      (i_Clk),
        .i_Rst      (i_Rst),
        .i_fKeyLoad (i_fKeyLoad),
        .i_Key      (i_Key),
        .i_fIvLoad  (i_fIvLoad),
        .i_Iv       (i_Iv),
        .i_Valid    (i_Valid),
        .o_Ready    (o_Ready),
        .i_fDec     (i_fDec),
        .i_fCbc     (i_fCbc),
        .i_Text     (i_Text),
        .o_Valid    (o_Valid),
        .i_Ready    (i_Ready),
        .o_Data     (o_Data),
        .o_fKeyRdy  (o_fKeyRdy)
    );

    always #5 i_Clk = ~i_Clk;

    always @(posedge i_Clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge i_Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] want);
        n_checks++;
        assert (obs === want) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, want);
        end
    endtask

    task automatic load_key(input logic [127:0] k);
        int n;
        i_Key      = k;
        i_fKeyLoad = 1'b1;
        tick();
        i_fKeyLoad = 1'b0;
        chk("key_busy", 128'(o_fKeyRdy), 128'd0);
        n = 0;
        while (!o_fKeyRdy && n < 40) begin
            chk("key_busy_ready", 128'(o_Ready), 128'd0);
            tick();
            n++;
        end
        chk("key_latency", 128'(n), 128'(KEY_LAT));
    endtask

    task automatic load_iv(input logic [127:0] v);
        i_Iv      = v;
        i_fIvLoad = 1'b1;
        tick();
        i_fIvLoad = 1'b0;
    endtask

    task automatic start_block(input logic [127:0] text, input logic dec, input logic cbc,
                               input logic [127:0] want);
        int n;
        n = 0;
        while (!o_Ready && n < 40) begin
            tick();
            n++;
        end
        i_Text  = text;
        i_fDec  = dec;
        i_fCbc  = cbc;
        i_Valid = 1'b1;
        exp_q.push_back(want);
        tick();
        acc_cyc = cyc;
        i_Valid = 1'b0;
    endtask

    task automatic wait_result(input string tag);
        int           n;
        logic [127:0] want;
        n = 0;
        while (!o_Valid && n < 40) begin
            tick();
            n++;
        end
        chk({tag, "_latency"}, 128'(cyc - acc_cyc), 128'(BLK_LAT));
        chk({tag, "_valid"}, 128'(o_Valid), 128'd1);
        if (exp_q.size() != 0) want = exp_q.pop_front();
        else                   want = 'x;
        chk({tag, "_data"}, o_Data, want);
        i_Ready = 1'b1;
        tick();
        i_Ready = 1'b0;
        chk({tag, "_drain_valid"}, 128'(o_Valid), 128'd0);
        chk({tag, "_drain_data"}, o_Data, 128'd0);
    endtask

    initial begin
        int           n;
        logic [127:0] hold;

        // Reset state, then no accept without a key.
        tick();
        tick();
        chk("rst_ready", 128'(o_Ready), 128'd0);
        chk("rst_valid", 128'(o_Valid), 128'd0);
        chk("rst_data", o_Data, 128'd0);
        chk("rst_keyrdy", 128'(o_fKeyRdy), 128'd0);
        i_Rst   = 1'b1;
        i_Valid = 1'b1;
        i_Text  = P1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("nokey_ready", 128'(o_Ready), 128'd0);
            chk("nokey_valid", 128'(o_Valid), 128'd0);
        end
        i_Valid = 1'b0;

        // FIPS-197 ECB encrypt then decrypt with the cached schedule.
        load_key(K1);
        start_block(P1, 1'b0, 1'b0, C1);
        wait_result("fips_enc");
        chk("fips_ready_direct", 128'(o_Ready), 128'd1);
        start_block(C1, 1'b1, 1'b0, P1);
        chk("fips_dec_keyrdy", 128'(o_fKeyRdy), 128'd1);
        wait_result("fips_dec");

        // Backpressure: result held for 20 cycles, pending block waits.
        start_block(P1, 1'b0, 1'b0, C1);
        n = 0;
        while (!o_Valid && n < 40) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0) hold = exp_q.pop_front();
        else                   hold = 'x;
        chk("bp_first_data", o_Data, hold);
        i_Text  = C1;
        i_fDec  = 1'b1;
        i_fCbc  = 1'b0;
        i_Valid = 1'b1;
        exp_q.push_back(P1);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("bp_hold_data", o_Data, hold);
            chk("bp_hold_ready", 128'(o_Ready), 128'd0);
        end
        i_Ready = 1'b1;
        tick();
        i_Ready = 1'b0;
        chk("bp_idle_valid", 128'(o_Valid), 128'd0);
        chk("bp_idle_ready", 128'(o_Ready), 128'd1);
        tick();
        acc_cyc = cyc;
        i_Valid = 1'b0;
        chk("bp_accepted", 128'(o_Ready), 128'd0);
        wait_result("bp_second");

        // SP800-38A CBC encrypt, then decrypt after reloading the IV.
        load_key(K2);
        load_iv(IV2);
        start_block(PA, 1'b0, 1'b1, CA);
        wait_result("cbc_enc1");
        start_block(PB, 1'b0, 1'b1, CB);
        wait_result("cbc_enc2");
        load_iv(IV2);
        start_block(CA, 1'b1, 1'b1, PA);
        wait_result("cbc_dec1");
        start_block(CB, 1'b1, 1'b1, PB);
        wait_result("cbc_dec2");

        // Key load and block valid in the same cycle: only the key is taken.
        i_Text     = PA;
        i_fDec     = 1'b0;
        i_fCbc     = 1'b0;
        i_Valid    = 1'b1;
        i_Key      = K2;
        i_fKeyLoad = 1'b1;
        #1;
        chk("kl_same_cycle_ready", 128'(o_Ready), 128'd0);
        tick();
        i_fKeyLoad = 1'b0;
        chk("kl_taken_keyrdy", 128'(o_fKeyRdy), 128'd0);
        chk("kl_taken_valid", 128'(o_Valid), 128'd0);
        n = 0;
        while (!o_fKeyRdy && n < 40) begin
            tick();
            n++;
        end
        chk("kl_latency", 128'(n), 128'(KEY_LAT));
        chk("kl_then_ready", 128'(o_Ready), 128'd1);
        exp_q.push_back(EA);
        tick();
        acc_cyc = cyc;
        i_Valid = 1'b0;
        wait_result("kl_block");

        // Reset in MIDDLE round 5: outputs clear, key must be rebuilt.
        start_block(PA, 1'b0, 1'b0, EA);
        for (int i = 0; i < 5; i++) tick();
        i_Rst = 1'b0;
        #1;
        chk("abort_valid", 128'(o_Valid), 128'd0);
        chk("abort_data", o_Data, 128'd0);
        chk("abort_ready", 128'(o_Ready), 128'd0);
        chk("abort_keyrdy", 128'(o_fKeyRdy), 128'd0);
        exp_q.delete();
        tick();
        i_Rst   = 1'b1;
        i_Text  = PA;
        i_Valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("abort_no_accept", 128'(o_Ready), 128'd0);
            chk("abort_no_valid", 128'(o_Valid), 128'd0);
        end
        load_key(K2);
        i_Valid = 1'b0;
        start_block(PA, 1'b0, 1'b0, EA);
        wait_result("post_abort");

        chk("scoreboard_empty", 128'(exp_q.size()), 128'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
